// File: rtl/loop_counter_2d_if.sv
// Handshake bundle for loop_counter_2d: start/advance inputs and the counted tuple with its flags.
// Master drives start_i/en_i and observes the tuple; slave is the counter itself.
interface loop_counter_2d_if #(
    parameter int WORD_SIZE = 16
);
    logic                 start_i;
    logic                 en_i;
    logic [WORD_SIZE-1:0] inner_o;
    logic [WORD_SIZE-1:0] outer_o;
    logic                 valid_o;
    logic                 last_inner_o;
    logic                 last_o;
    logic                 done_o;

    modport master (
        output start_i,
        output en_i,
        input  inner_o,
        input  outer_o,
        input  valid_o,
        input  last_inner_o,
        input  last_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  en_i,
        output inner_o,
        output outer_o,
        output valid_o,
        output last_inner_o,
        output last_o,
        output done_o
    );
endinterface

// File: rtl/loop_counter_2d.sv
// Two-level row-major loop counter: outer 0..OUTER_MAX, inner 0..INNER_MAX, one tuple per en_i.
// Define LOOP_COUNTER_2D_AUTO_RESTART_EN to wrap straight into the next sweep instead of idling.
module loop_counter_2d #(
    parameter int WORD_SIZE = 16,
    parameter int INNER_MAX = 10,
    parameter int OUTER_MAX = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    loop_counter_2d_if.slave bus
);

    typedef enum logic {
        eIDLE  = 1'b0,
        eCOUNT = 1'b1
    } state_t;

    localparam logic [WORD_SIZE-1:0] INNER_LAST = WORD_SIZE'(INNER_MAX);
    localparam logic [WORD_SIZE-1:0] OUTER_LAST = WORD_SIZE'(OUTER_MAX);
    localparam logic [WORD_SIZE-1:0] ONE        = WORD_SIZE'(1);

    // Bounds must be non-negative and representable in the count width.
    generate
        if (WORD_SIZE < 1 || WORD_SIZE > 32) begin : g_bad_width
            $error("loop_counter_2d: WORD_SIZE must be in 1..32");
        end
        if (INNER_MAX < 0 || (WORD_SIZE < 31 && INNER_MAX > (2 ** WORD_SIZE) - 1)) begin : g_bad_inner
            $error("loop_counter_2d: INNER_MAX negative or wider than WORD_SIZE");
        end
        if (OUTER_MAX < 0 || (WORD_SIZE < 31 && OUTER_MAX > (2 ** WORD_SIZE) - 1)) begin : g_bad_outer
            $error("loop_counter_2d: OUTER_MAX negative or wider than WORD_SIZE");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] inner_q, inner_d;
    logic [WORD_SIZE-1:0] outer_q, outer_d;
    logic                 done_q,  done_d;

    logic at_inner_last;
    logic at_outer_last;

    assign at_inner_last = (inner_q == INNER_LAST);
    assign at_outer_last = (outer_q == OUTER_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
            inner_q <= '0;
            outer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inner_d = inner_q;
        outer_d = outer_q;
        done_d  = 1'b0;
        case (state_q)
            eIDLE: begin
                if (bus.start_i) begin
                    state_d = eCOUNT;
                    inner_d = '0;
                    outer_d = '0;
                end
            end
            eCOUNT: begin
                if (bus.en_i) begin
                    if (!at_inner_last) begin
                        inner_d = inner_q + ONE;
                    end else if (!at_outer_last) begin
                        inner_d = '0;
                        outer_d = outer_q + ONE;
                    end else begin
                        // Final tuple consumed: clear counts and flag completion.
                        inner_d = '0;
                        outer_d = '0;
                        done_d  = 1'b1;
`ifdef LOOP_COUNTER_2D_AUTO_RESTART_EN
                        state_d = eCOUNT;
`else
                        state_d = eIDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = eIDLE;
                inner_d = '0;
                outer_d = '0;
            end
        endcase
    end

    assign bus.valid_o      = (state_q == eCOUNT);
    assign bus.inner_o      = inner_q;
    assign bus.outer_o      = outer_q;
    assign bus.last_inner_o = (state_q == eCOUNT) && at_inner_last;
    assign bus.last_o       = (state_q == eCOUNT) && at_inner_last && at_outer_last;
    assign bus.done_o       = done_q;

endmodule
